// File: rtl/chacha_round_engine_pkg.sv
// ============================================================================
//  Module      : chacha_round_engine_pkg
//  Description : Shared constants, FSM state encoding and byte-swap helper
//                for the ChaCha round engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chacha_round_engine_pkg;

  // "expand 32-byte k" constant words for 256-bit keys
  localparam logic [31:0] C_SIGMA_0 = 32'h61707865;
  localparam logic [31:0] C_SIGMA_1 = 32'h3320646e;
  localparam logic [31:0] C_SIGMA_2 = 32'h79622d32;
  localparam logic [31:0] C_SIGMA_3 = 32'h6b206574;

  // "expand 16-byte k" constant words for 128-bit keys
  localparam logic [31:0] C_TAU_0 = 32'h61707865;
  localparam logic [31:0] C_TAU_1 = 32'h3120646e;
  localparam logic [31:0] C_TAU_2 = 32'h79622d36;
  localparam logic [31:0] C_TAU_3 = 32'h6b206574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ROUND = 2'd2,
    ST_FINAL = 2'd3
  } state_e;

  // Reverse byte order of a 32-bit word (big-endian port order <-> LE state word)
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/chacha_round_engine_if.sv
// ============================================================================
//  Module      : chacha_round_engine_if
//  Description : Request / keystream bus between the stream-cipher datapath
//                (master) and the ChaCha round engine (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chacha_round_engine_if;

  logic         init;
  logic         next;
  logic         keylen;
  logic [255:0] key;
  logic [63:0]  iv;
  logic [63:0]  ctr;
  logic         ready;
  logic [511:0] data_out;
  logic         data_out_valid;

  modport master (
    output init, next, keylen, key, iv, ctr,
    input  ready, data_out, data_out_valid
  );

  modport slave (
    input  init, next, keylen, key, iv, ctr,
    output ready, data_out, data_out_valid
  );

endinterface

`default_nettype wire

// File: rtl/chacha_qr.sv
// ============================================================================
//  Module      : chacha_qr
//  Description : Combinational ChaCha quarterround (add/xor/rotate 16,12,8,7).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chacha_qr (
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  input  wire logic [31:0] c,
  input  wire logic [31:0] d,
  output logic      [31:0] a_new,
  output logic      [31:0] b_new,
  output logic      [31:0] c_new,
  output logic      [31:0] d_new
);

  logic [31:0] w_a0, w_d0, w_d1, w_c0, w_b0, w_b1;
  logic [31:0] w_a1, w_d2, w_d3, w_c1, w_b2, w_b3;

  assign w_a0 = a + b;
  assign w_d0 = d ^ w_a0;
  assign w_d1 = {w_d0[15:0], w_d0[31:16]};
  assign w_c0 = c + w_d1;
  assign w_b0 = b ^ w_c0;
  assign w_b1 = {w_b0[19:0], w_b0[31:20]};

  assign w_a1 = w_a0 + w_b1;
  assign w_d2 = w_d1 ^ w_a1;
  assign w_d3 = {w_d2[23:0], w_d2[31:24]};
  assign w_c1 = w_c0 + w_d3;
  assign w_b2 = w_b1 ^ w_c1;
  assign w_b3 = {w_b2[24:0], w_b2[31:25]};

  assign a_new = w_a1;
  assign b_new = w_b3;
  assign c_new = w_c1;
  assign d_new = w_d3;

endmodule

`default_nettype wire

// File: rtl/chacha_round_engine.sv
// ============================================================================
//  Module      : chacha_round_engine
//  Description : Iterative ChaCha block engine. Builds the 16-word state,
//                runs one column/diagonal half-round per cycle on four
//                parallel quarterrounds, adds the saved state back and
//                presents a 512-bit keystream block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chacha_round_engine
  import chacha_round_engine_pkg::*;
#(
  parameter int          ROUNDS   = 20,   // even, one of 8/12/20
  parameter logic [63:0] CTR_INIT = 64'h0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  chacha_round_engine_if.slave  bus
);

  localparam int RW = $clog2(ROUNDS);

  state_e         r_state;
  state_e         w_state_next;

  logic [255:0]   r_key;
  logic           r_keylen;
  logic [63:0]    r_iv;
  logic [63:0]    r_ctr;
  logic [RW-1:0]  r_round;
  logic [31:0]    r_x [16];
  logic [31:0]    r_s [16];
  logic [511:0]   r_data_out;
  logic           r_valid;

  logic           w_take_init;
  logic           w_take_next;
  logic [31:0]    w_init [16];
  logic [31:0]    w_x_qr [16];
  logic [31:0]    w_qa [4], w_qb [4], w_qc [4], w_qd [4];
  logic [31:0]    w_na [4], w_nb [4], w_nc [4], w_nd [4];

  // Requests are only honoured while idle; init has priority over next
  assign w_take_init = (r_state == ST_IDLE) && bus.init;
  assign w_take_next = (r_state == ST_IDLE) && !bus.init && bus.next;

  assign bus.ready          = (r_state == ST_IDLE);
  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_valid;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_take_init || w_take_next) w_state_next = ST_INIT;
      ST_INIT:  w_state_next = ST_ROUND;
      ST_ROUND: if (r_round == RW'(ROUNDS - 1)) w_state_next = ST_FINAL;
      ST_FINAL: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Initial state words from constants, held key, counter and nonce.
  // The counter is a plain 64-bit number, so its halves go in as-is;
  // key and nonce arrive in byte order and are swapped to LE words.
  always_comb begin
    for (int i = 0; i < 16; i++) w_init[i] = 32'h0;
    w_init[0] = r_keylen ? C_SIGMA_0 : C_TAU_0;
    w_init[1] = r_keylen ? C_SIGMA_1 : C_TAU_1;
    w_init[2] = r_keylen ? C_SIGMA_2 : C_TAU_2;
    w_init[3] = r_keylen ? C_SIGMA_3 : C_TAU_3;
    for (int i = 0; i < 4; i++) begin
      w_init[4 + i] = bswap32(r_key[255 - 32*i -: 32]);
      w_init[8 + i] = r_keylen ? bswap32(r_key[127 - 32*i -: 32])
                               : bswap32(r_key[255 - 32*i -: 32]);
    end
    w_init[12] = r_ctr[31:0];
    w_init[13] = r_ctr[63:32];
    w_init[14] = bswap32(r_iv[63:32]);
    w_init[15] = bswap32(r_iv[31:0]);
  end

  // Four quarterrounds; round bit 0 selects column (0) or diagonal (1) operands
  for (genvar k = 0; k < 4; k++) begin : g_qr
    localparam int DB = 4  + ((k + 1) % 4);
    localparam int DC = 8  + ((k + 2) % 4);
    localparam int DD = 12 + ((k + 3) % 4);

    assign w_qa[k] = r_x[k];
    assign w_qb[k] = r_round[0] ? r_x[DB] : r_x[4  + k];
    assign w_qc[k] = r_round[0] ? r_x[DC] : r_x[8  + k];
    assign w_qd[k] = r_round[0] ? r_x[DD] : r_x[12 + k];

    chacha_qr u_qr (
      .a     (w_qa[k]),
      .b     (w_qb[k]),
      .c     (w_qc[k]),
      .d     (w_qd[k]),
      .a_new (w_na[k]),
      .b_new (w_nb[k]),
      .c_new (w_nc[k]),
      .d_new (w_nd[k])
    );
  end

  // Route quarterround results back to the words they were taken from
  always_comb begin
    for (int i = 0; i < 16; i++) w_x_qr[i] = r_x[i];
    for (int k = 0; k < 4; k++) begin
      w_x_qr[k] = w_na[k];
      if (r_round[0]) begin
        w_x_qr[4  + ((k + 1) % 4)] = w_nb[k];
        w_x_qr[8  + ((k + 2) % 4)] = w_nc[k];
        w_x_qr[12 + ((k + 3) % 4)] = w_nd[k];
      end else begin
        w_x_qr[4  + k] = w_nb[k];
        w_x_qr[8  + k] = w_nc[k];
        w_x_qr[12 + k] = w_nd[k];
      end
    end
  end

  // Hold registers, working/saved state, round counter and output block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key      <= '0;
      r_keylen   <= 1'b0;
      r_iv       <= '0;
      r_ctr      <= CTR_INIT;
      r_round    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_x[i] <= '0;
        r_s[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_init) begin
            r_key    <= bus.key;
            r_keylen <= bus.keylen;
            r_iv     <= bus.iv;
            r_ctr    <= bus.ctr;
            r_valid  <= 1'b0;
          end else if (w_take_next) begin
            r_ctr    <= r_ctr + 64'd1;
            r_valid  <= 1'b0;
          end
        end
        ST_INIT: begin
          r_round <= '0;
          for (int i = 0; i < 16; i++) begin
            r_x[i] <= w_init[i];
            r_s[i] <= w_init[i];
          end
        end
        ST_ROUND: begin
          r_round <= r_round + 1'b1;
          for (int i = 0; i < 16; i++) r_x[i] <= w_x_qr[i];
        end
        ST_FINAL: begin
          for (int i = 0; i < 16; i++)
            r_data_out[511 - 32*i -: 32] <= bswap32(r_x[i] + r_s[i]);
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chacha_round_engine.sv
// ============================================================================
//  Module      : tb_chacha_round_engine
//  Description : Directed self-checking bench for chacha_round_engine with
//                20-, 8- and 12-round builds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chacha_round_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  chacha_round_engine_if bus20 ();
  chacha_round_engine_if bus8 ();
  chacha_round_engine_if bus12 ();

  chacha_round_engine #(.ROUNDS(20)) dut20 (.clk(clk), .reset(rst), .bus(bus20.slave));
  chacha_round_engine #(.ROUNDS(8))  dut8  (.clk(clk), .reset(rst), .bus(bus8.slave));
  chacha_round_engine #(.ROUNDS(12)) dut12 (.clk(clk), .reset(rst), .bus(bus12.slave));

  localparam logic [255:0] ZERO_TOP =
    256'h76b8e0ada0f13d90405d6ae55386bd28bdd219b8a08ded1aa836efcc8b770dc7;
  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 =
    256'hdeadbeefcafef00d0123456789abcdeffedcba987654321011223344aabbccdd;
  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};

  // ---------------- reference model (straight C-style ChaCha) -------------
  function automatic logic [31:0] le(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] qr4(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model(input logic [255:0] k, input logic kl,
                                         input logic [63:0] n, input logic [63:0] c,
                                         input int rounds);
    logic [31:0]  x [16];
    logic [31:0]  s [16];
    logic [511:0] res;
    x[0] = 32'h61707865;
    x[1] = kl ? 32'h3320646e : 32'h3120646e;
    x[2] = kl ? 32'h79622d32 : 32'h79622d36;
    x[3] = 32'h6b206574;
    for (int i = 0; i < 4; i++) begin
      x[4 + i] = le(k[255 - 32*i -: 32]);
      x[8 + i] = kl ? le(k[127 - 32*i -: 32]) : le(k[255 - 32*i -: 32]);
    end
    x[12] = c[31:0];
    x[13] = c[63:32];
    x[14] = le(n[63:32]);
    x[15] = le(n[31:0]);
    for (int i = 0; i < 16; i++) s[i] = x[i];
    for (int r = 0; r < rounds; r += 2) begin
      {x[0], x[4], x[8],  x[12]} = qr4(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr4(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr4(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr4(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr4(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr4(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr4(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr4(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) res[511 - 32*i -: 32] = le(x[i] + s[i]);
    return res;
  endfunction

  // ---------------- stimulus helpers ------------------------------------
  // One-cycle request pulse on the 20-round DUT; returns on the negedge after the sampling edge
  task automatic drive20(input logic do_init, input logic do_next, input logic [255:0] k,
                         input logic kl, input logic [63:0] n, input logic [63:0] c);
    @(negedge clk);
    bus20.init = do_init; bus20.next = do_next;
    bus20.key = k; bus20.keylen = kl; bus20.iv = n; bus20.ctr = c;
    @(negedge clk);
    bus20.init = 1'b0; bus20.next = 1'b0;
  endtask

  // Count negedge samples with ready low (bounded)
  task automatic wait_idle20(output int low);
    low = 0;
    while (bus20.ready !== 1'b1 && low < 200) begin
      low++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests -----------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus20.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus20.ready); end
    total++; if (bus20.data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus20.data_out_valid); end
    total++; if (bus20.data_out !== 512'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus20.data_out); end
    total++; if (bus8.ready !== 1'b1 || bus12.ready !== 1'b1) begin bad++; $display("FAIL reset_ready_short got=%b%b want=11", bus8.ready, bus12.ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_vector;
    int low;
    drive20(1'b1, 1'b0, 256'h0, 1'b1, 64'h0, 64'h0);
    wait_idle20(low);
    total++; if (low !== 22) begin bad++; $display("FAIL zero_latency got=%0d want=22", low); end
    total++; if (bus20.data_out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", bus20.data_out_valid); end
    total++; if (bus20.data_out[511:256] !== ZERO_TOP) begin bad++; $display("FAIL zero_vector got=%h want=%h", bus20.data_out[511:256], ZERO_TOP); end
    total++; if (bus20.data_out !== model(256'h0, 1'b1, 64'h0, 64'h0, 20)) begin bad++; $display("FAIL zero_model got=%h want=%h", bus20.data_out, model(256'h0, 1'b1, 64'h0, 64'h0, 20)); end
  endtask

  task automatic test_next;
    int low;
    // Inputs on the bus are deliberately different: next must reuse the held key/iv
    drive20(1'b0, 1'b1, K2, 1'b0, 64'h1234, 64'h99);
    wait_idle20(low);
    total++; if (low !== 22) begin bad++; $display("FAIL next_ready_low got=%0d want=22", low); end
    total++; if (bus20.data_out !== model(256'h0, 1'b1, 64'h0, 64'h1, 20)) begin bad++; $display("FAIL next_block got=%h want=%h", bus20.data_out, model(256'h0, 1'b1, 64'h0, 64'h1, 20)); end
  endtask

  task automatic test_reset_mid_round;
    int low;
    drive20(1'b1, 1'b0, K1, 1'b1, 64'h0706050403020100, 64'h7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus20.ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", bus20.ready); end
    total++; if (bus20.data_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus20.data_out_valid); end
    total++; if (bus20.data_out !== 512'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", bus20.data_out); end
    @(negedge clk);
    rst = 1'b0;
    drive20(1'b1, 1'b0, K1, 1'b1, 64'h0706050403020100, 64'h7);
    wait_idle20(low);
    total++; if (low !== 22) begin bad++; $display("FAIL midrst_relatency got=%0d want=22", low); end
    total++; if (bus20.data_out !== model(K1, 1'b1, 64'h0706050403020100, 64'h7, 20)) begin bad++; $display("FAIL midrst_block got=%h want=%h", bus20.data_out, model(K1, 1'b1, 64'h0706050403020100, 64'h7, 20)); end
  endtask

  task automatic test_ctr_wrap;
    int low;
    drive20(1'b1, 1'b0, K2, 1'b1, 64'h0102030405060708, 64'hffffffffffffffff);
    wait_idle20(low);
    total++; if (bus20.data_out !== model(K2, 1'b1, 64'h0102030405060708, 64'hffffffffffffffff, 20)) begin bad++; $display("FAIL wrap_first got=%h want=%h", bus20.data_out, model(K2, 1'b1, 64'h0102030405060708, 64'hffffffffffffffff, 20)); end
    drive20(1'b0, 1'b1, K1, 1'b0, 64'h0, 64'h5);
    wait_idle20(low);
    total++; if (bus20.data_out !== model(K2, 1'b1, 64'h0102030405060708, 64'h0, 20)) begin bad++; $display("FAIL wrap_second got=%h want=%h", bus20.data_out, model(K2, 1'b1, 64'h0102030405060708, 64'h0, 20)); end
  endtask

  task automatic test_back_to_back;
    int   rises;
    logic prev;
    @(negedge clk);
    bus20.init = 1'b1; bus20.next = 1'b1;
    bus20.key = K1; bus20.keylen = 1'b1; bus20.iv = 64'h00000000000000aa; bus20.ctr = 64'h5;
    prev  = bus20.data_out_valid;
    rises = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      bus20.next = 1'b0;
      bus20.init = (cyc == 2 || cyc == 9 || cyc == 16);
      bus20.key  = K2;
      bus20.ctr  = 64'h63;
      if (bus20.data_out_valid === 1'b1 && prev !== 1'b1) rises++;
      prev = bus20.data_out_valid;
    end
    total++; if (rises !== 1) begin bad++; $display("FAIL busy_blocks got=%0d want=1", rises); end
    total++; if (bus20.data_out !== model(K1, 1'b1, 64'h00000000000000aa, 64'h5, 20)) begin bad++; $display("FAIL init_wins_block got=%h want=%h", bus20.data_out, model(K1, 1'b1, 64'h00000000000000aa, 64'h5, 20)); end
  endtask

  task automatic test_short_rounds;
    int low8, low12;
    bit done8, done12;
    @(negedge clk);
    bus8.init = 1'b1;  bus8.key = K128;  bus8.keylen = 1'b0;  bus8.iv = 64'h0;  bus8.ctr = 64'h0;
    bus12.init = 1'b1; bus12.key = K128; bus12.keylen = 1'b0; bus12.iv = 64'h0; bus12.ctr = 64'h0;
    @(negedge clk);
    bus8.init = 1'b0; bus12.init = 1'b0;
    low8 = 0; low12 = 0; done8 = 0; done12 = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (!done8)  begin if (bus8.ready === 1'b1)  done8 = 1;  else low8++;  end
      if (!done12) begin if (bus12.ready === 1'b1) done12 = 1; else low12++; end
      @(negedge clk);
    end
    total++; if (low8 !== 10) begin bad++; $display("FAIL r8_latency got=%0d want=10", low8); end
    total++; if (low12 !== 14) begin bad++; $display("FAIL r12_latency got=%0d want=14", low12); end
    total++; if (bus8.data_out !== model(K128, 1'b0, 64'h0, 64'h0, 8)) begin bad++; $display("FAIL r8_block got=%h want=%h", bus8.data_out, model(K128, 1'b0, 64'h0, 64'h0, 8)); end
    total++; if (bus12.data_out !== model(K128, 1'b0, 64'h0, 64'h0, 12)) begin bad++; $display("FAIL r12_block got=%h want=%h", bus12.data_out, model(K128, 1'b0, 64'h0, 64'h0, 12)); end
  endtask

  initial begin
    bus20.init = 1'b0; bus20.next = 1'b0; bus20.keylen = 1'b0; bus20.key = '0; bus20.iv = '0; bus20.ctr = '0;
    bus8.init  = 1'b0; bus8.next  = 1'b0; bus8.keylen  = 1'b0; bus8.key  = '0; bus8.iv  = '0; bus8.ctr  = '0;
    bus12.init = 1'b0; bus12.next = 1'b0; bus12.keylen = 1'b0; bus12.key = '0; bus12.iv = '0; bus12.ctr = '0;
    test_reset();
    test_zero_vector();
    test_next();
    test_reset_mid_round();
    test_ctr_wrap();
    test_back_to_back();
    test_short_rounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
